// File: rtl/data_memory_wbuf.sv
// data_memory_wbuf: word-addressed data memory behind a posted-write FIFO.
// CPU writes are queued and retire to the array whenever the single array
// port is not needed for a read; reads forward from the buffer youngest-first.
// Optional build macro WB_MERGE_EN: a write that hits a buffered entry
// overwrites that entry in place instead of taking a new slot.
//
// Handshake: stall is the inverse of ready. A request (we and/or re) is
// performed at the rising edge only in a cycle where stall is low; while
// stall is high the CPU must hold a, we, re and wd and present them again.
module data_memory_wbuf #(
  parameter int ADDR_W   = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 a,
  input  logic                        we,
  input  logic                        re,
  input  logic [31:0]                 wd,
  output logic [31:0]                 rd,
  output logic                        stall,
  output logic [$clog2(WB_DEPTH):0]   wb_count
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]       mem    [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wb_idx [WB_DEPTH];
  logic [31:0]       wb_dat [WB_DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] idx;
  logic full, do_retire, do_push, do_merge;
  logic fwd_hit;
  logic [PW-1:0] fwd_pos, scan_pos;

  // Address bits outside the word index are intentionally ignored.
  logic unused_a;
  assign unused_a = ^{a[31:ADDR_W+2], a[1:0]};

  assign idx      = a[ADDR_W+1:2];
  assign full     = (count == CW'(WB_DEPTH));
  assign wb_count = count;

  // The array port retires the head unless a read needs it; being full
  // forces the retire so a stall never lasts more than one cycle.
  assign do_retire = (count != '0) & (~re | full);

  // Scan valid entries oldest to youngest; the last match is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_pos  = head;
    scan_pos = head;
    for (int i = 0; i < WB_DEPTH; i++) begin
      scan_pos = head + PW'(i);
      if ((CW'(i) < count) && (wb_idx[scan_pos] == idx)) begin
        fwd_hit = 1'b1;
        fwd_pos = scan_pos;
      end
    end
  end

`ifdef WB_MERGE_EN
  logic merge_hit;
  // A hit on the head that retires this cycle cannot be merged into.
  assign merge_hit = fwd_hit & ~(do_retire & (fwd_pos == head));
  assign stall     = full & ((we & ~merge_hit) | re);
  assign do_merge  = we & merge_hit & ~stall;
  assign do_push   = we & ~merge_hit & ~stall;
`else
  assign stall     = full & (we | re);
  assign do_merge  = 1'b0;
  assign do_push   = we & ~stall;
`endif

  // Read data: forwarded buffer entry on a performed read, else the array.
  assign rd = (re & ~stall & fwd_hit) ? wb_dat[fwd_pos] : mem[idx];

  // Buffer pointers and occupancy; reset drops all pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push)   tail <= tail + 1'b1;
      if (do_retire) head <= head + 1'b1;
      count <= count + CW'(do_push) - CW'(do_retire);
    end
  end

  // Buffer payload: new entry at the tail, or in-place merge.
  always_ff @(posedge clk) begin
    if (do_push) begin
      wb_idx[tail] <= idx;
      wb_dat[tail] <= wd;
    end
    if (do_merge) begin
      wb_dat[fwd_pos] <= wd;
    end
  end

  // Storage array: written only by retiring the buffer head.
  always_ff @(posedge clk) begin
    if (do_retire) begin
      mem[wb_idx[head]] <= wb_dat[head];
    end
  end

endmodule
